// File: rtl/ex_issue_buffer_pkg.sv
// Common types for the execute-stage issue path.
// control_type      : decoded control bundle; all-zero encodes a NOP.
// ex_operands_type  : one complete execute-stage operand bundle (head/skid entry).
// count_type        : issue buffer occupancy.
package ex_issue_buffer_pkg;

   localparam int EX_DATA_W      = 32;
   localparam int EX_ISSUE_DEPTH = 2;

   typedef struct packed {
      logic [3:0] alu_op;
      logic [2:0] funct3;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       branch;
      logic       jump;
   } control_type;

   typedef struct packed {
      logic [EX_DATA_W-1:0] data1;
      logic [EX_DATA_W-1:0] data2;
      logic [EX_DATA_W-1:0] immediate_data;
      control_type          control;
      logic                 compflg;
      logic [EX_DATA_W-1:0] program_counter;
   } ex_operands_type;

   typedef enum logic [$clog2(EX_ISSUE_DEPTH+1)-1:0] {
      CNT_EMPTY = 0,
      CNT_ONE   = 1,
      CNT_FULL  = 2
   } count_type;

endpackage

// File: rtl/ex_issue_buffer.sv
// Two-entry skid buffer between decode and execute.
//
// state     | meaning
// ----------+------------------------------------------------
// CNT_EMPTY | nothing held, ex_* all zero, out_valid=0
// CNT_ONE   | head holds the oldest bundle, skid empty
// CNT_FULL  | head and skid both hold bundles, in_ready=0
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    drop every held bundle (branch/jump redirect)
//   in_valid/in_ready        decode-side handshake
//   in_*                     incoming operand bundle
//   out_valid/out_ready      execute-side handshake
//   ex_*                     head bundle operands (all zero while empty)
//   bubble_count             saturating count of cycles execute was starved
module ex_issue_buffer
   import ex_issue_buffer_pkg::*;
#(
   parameter int DATA_W = EX_DATA_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data1,
   input  logic [DATA_W-1:0] in_data2,
   input  logic [DATA_W-1:0] in_immediate_data,
   input  control_type       in_control,
   input  logic              in_compflg,
   input  logic [DATA_W-1:0] in_program_counter,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] ex_data1,
   output logic [DATA_W-1:0] ex_data2,
   output logic [DATA_W-1:0] ex_immediate_data,
   output control_type       ex_control,
   output logic              ex_compflg,
   output logic [DATA_W-1:0] ex_program_counter,
   output logic [CNT_W-1:0]  bubble_count
);

   count_type        count_q, count_d;
   ex_operands_type  head_q, head_d;
   ex_operands_type  skid_q, skid_d;
   ex_operands_type  in_bundle;
   logic [CNT_W-1:0] bubble_q, bubble_d;
   logic             push;
   logic             pop;

   assign in_bundle.data1           = in_data1;
   assign in_bundle.data2           = in_data2;
   assign in_bundle.immediate_data  = in_immediate_data;
   assign in_bundle.control         = in_control;
   assign in_bundle.compflg         = in_compflg;
   assign in_bundle.program_counter = in_program_counter;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= CNT_EMPTY;
         head_q   <= '0;
         skid_q   <= '0;
         bubble_q <= '0;
      end else begin
         count_q  <= count_d;
         head_q   <= head_d;
         skid_q   <= skid_d;
         bubble_q <= bubble_d;
      end
   end

   // Vacated entries are zeroed so ex_* reads as a NOP whenever out_valid=0.
   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
         count_d = CNT_EMPTY;
         head_d  = '0;
         skid_d  = '0;
      end else begin
         case (count_q)
            CNT_EMPTY: begin
               if (push) begin
                  head_d  = in_bundle;
                  count_d = CNT_ONE;
               end
            end
            CNT_ONE: begin
               case ({push, pop})
                  2'b10: begin
                     skid_d  = in_bundle;
                     count_d = CNT_FULL;
                  end
                  2'b01: begin
                     head_d  = '0;
                     count_d = CNT_EMPTY;
                  end
                  2'b11: head_d = in_bundle;
                  default: ;
               endcase
            end
            CNT_FULL: begin
               if (pop) begin
                  head_d  = skid_q;
                  skid_d  = '0;
                  count_d = CNT_ONE;
               end
            end
            default: begin
               count_d = CNT_EMPTY;
               head_d  = '0;
               skid_d  = '0;
            end
         endcase
      end
   end

   always_comb begin
      bubble_d = bubble_q;
      if (out_ready && !out_valid && !flush && (bubble_q != '1)) begin
         bubble_d = bubble_q + 1'b1;
      end
   end

   // in_ready never looks at out_ready, so no combinational path runs from
   // execute back into decode.
   always_comb begin
      in_ready           = (count_q != CNT_FULL) && !flush;
      out_valid          = (count_q != CNT_EMPTY);
      ex_data1           = head_q.data1;
      ex_data2           = head_q.data2;
      ex_immediate_data  = head_q.immediate_data;
      ex_control         = head_q.control;
      ex_compflg         = head_q.compflg;
      ex_program_counter = head_q.program_counter;
      bubble_count       = bubble_q;
   end

endmodule
